mult_operand_sequencer: RTL and testbench
=========================================

# mult_operand_sequencer

Byte-serial front/back end for the 8x8 array multiplier core. Collects operand A then operand B from an 8-bit input stream with a valid/ready handshake, presents them to the combinational multiplier, and waits a programmable number of cycles for the product. It captures the 16-bit product and returns it as two bytes, low byte first, over a second valid/ready handshake. It sits between the tile's pin-level I/O and the array multiplier instance.

## Interface
- `WIDTH`, default 8: operand width; the product is 2*WIDTH bits.
- `MUL_LAT`, default 0: extra wait cycles for multiplier settling or pipelining; range 0..7.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_data` in WIDTH: operand byte.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: sequencer accepts an operand byte this cycle.
- `op_a` out WIDTH: registered operand A, routed to the multiplier.
- `op_b` out WIDTH: registered operand B, routed to the multiplier.
- `product` in 2*WIDTH: combinational product from the multiplier.
- `out_data` out WIDTH: result byte.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: consumer accepts `out_data`.
- `busy` out 1: high in any state other than LOAD_A.
- `acc_clr` in 1: synchronous accumulator clear. Present only when `MULT_ACCUM_EN` is defined.

## Operation
- FSM states: LOAD_A, LOAD_B, CALC, OUT_LO, OUT_HI.
- Handshakes: an input transfer occurs on an edge where `in_valid && in_ready`. An output transfer occurs on an edge where `out_valid && out_ready`.
- LOAD_A:
  - `in_ready`=1.
  - On transfer: `op_a` <= `in_data`, go to LOAD_B.
- LOAD_B:
  - `in_ready`=1.
  - On transfer: `op_b` <= `in_data`, clear the wait counter, go to CALC.
- CALC:
  - `in_ready`=0.
  - The wait counter increments each cycle.
  - On the cycle where the counter equals `MUL_LAT`: `result` <= `product`, go to OUT_LO.
- OUT_LO:
  - `out_valid`=1, `out_data`=`result[WIDTH-1:0]`.
  - On transfer: go to OUT_HI.
- OUT_HI:
  - `out_valid`=1, `out_data`=`result[2*WIDTH-1:WIDTH]`.
  - On transfer: go to LOAD_A.
- Decoded outputs:
  - `in_ready`, `out_valid` and `busy` are decoded from state only, never from same-cycle inputs.
  - `out_data` holds stable while `out_valid`=1 and `out_ready`=0.
- Register lifetime:
  - `op_a` and `op_b` hold their values until overwritten by the next transfer into their own state. They are not cleared after a result.
  - `op_a` therefore changes while `op_b` still holds the previous operand. This is harmless because `product` is sampled only in CALC.
- Arithmetic: unsigned. The product always fits in 2*WIDTH bits, with no truncation (255*255 = 0xFE01).
- Input stalls: `in_valid`=0 in a LOAD state holds that state indefinitely. `in_data` is ignored outside LOAD states.
- Output stalls: `out_ready`=0 in an OUT state holds that state indefinitely. `out_ready` is ignored outside OUT states.
- Reset mid-operation: asserting `rst` in any state immediately returns to LOAD_A. Partially loaded operands and an unsent result are discarded.

## Timing
- Reset values:
  - State = LOAD_A; `op_a`, `op_b`, `result`, accumulator and wait counter = 0.
  - `in_ready`=1, `out_valid`=0, `out_data`=0, `busy`=0.
- Input rate: back-to-back acceptance of the A and B bytes on consecutive edges is supported.
- Latency:
  - B accepted on edge k. CALC occupies cycles k..k+MUL_LAT.
  - `product` is sampled on edge k+MUL_LAT+1, and `out_valid` rises after that same edge.
  - With `MUL_LAT`=0, `out_valid` rises one cycle after B acceptance.
- Output rate: with `out_ready` held at 1, the low and high bytes transfer on consecutive edges. `in_ready` rises the cycle after the high-byte transfer.
- Throughput:
  - Minimum transaction = 2 + (MUL_LAT+1) + 2 cycles.
  - There is no overlap between output and loading of the next operands.

## Configuration
- `MULT_ACCUM_EN` defined:
  - The block becomes a multiply-accumulate.
  - In CALC, the captured value is `acc + product`, written to both `acc` and `result`.
  - The sum is modulo 2^(2*WIDTH) and wraps silently.
  - `acc_clr` zeroes `acc` on the edge it is sampled high. If a CALC capture occurs on that same edge, clear wins and `result` gets `product` alone.
- `MULT_ACCUM_EN` undefined:
  - `result` = `product`.
  - The `acc_clr` port and the accumulator register do not exist.

## Test plan
- Reset, then A=0x0C, B=0x0D, `out_ready`=1 -> bytes 0x9C then 0x00; `in_ready` returns to 1 two cycles after `out_valid` rises.
- A=0xFF, B=0xFF, `MUL_LAT`=3 -> `out_valid` rises exactly 4 cycles after B acceptance; bytes 0x01 then 0xFE.
- A=0x10, B=0x10 with `out_ready` low for 5 cycles -> `out_data` holds 0x00 and state holds in OUT_LO; after release, bytes 0x00 then 0x01.
- `in_valid` gapped between A=0x03 and B=0x05 -> no spurious transfer; bytes 0x0F then 0x00.
- Assert `rst` during CALC after A=0x07, B=0x09 -> `out_valid` never rises; `in_ready`=1, `op_a`=`op_b`=0; the next transaction 2*3 returns 0x06, 0x00.
- `MULT_ACCUM_EN`: 0xFF*0xFF twice without `acc_clr` -> second result 0xFC02 (wrapped 0x1FC02); after an `acc_clr` pulse, 2*3 -> 0x0006.

Source files
------------

// File: rtl/mult_operand_sequencer.sv
// Byte-serial operand loader and product unloader for the array multiplier core.
// Optional multiply-accumulate mode is enabled by defining MULT_ACCUM_EN.
module mult_operand_sequencer #(
  parameter int WIDTH   = 8,
  parameter int MUL_LAT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     op_a,
  output logic [WIDTH-1:0]     op_b,
  input  logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
`ifdef MULT_ACCUM_EN
  ,
  input  logic                 acc_clr
`endif
);

  typedef enum logic [2:0] {
    LOAD_A = 3'd0,
    LOAD_B = 3'd1,
    CALC   = 3'd2,
    OUT_LO = 3'd3,
    OUT_HI = 3'd4
  } state_t;

  localparam logic [2:0] LP_LAT = 3'(MUL_LAT);

  state_t               r_state;
  logic [2:0]           r_cnt;
  logic [2*WIDTH-1:0]   r_result;
  logic [2*WIDTH-1:0]   w_cap;
  logic                 w_capture;

  assign w_capture = (r_state == CALC) && (r_cnt == LP_LAT);

`ifdef MULT_ACCUM_EN
  logic [2*WIDTH-1:0]   r_acc;

  // A same-edge clear wins, so the capture then sees the bare product.
  always_comb begin
    w_cap = product;
    if (acc_clr) begin
      w_cap = product;
    end else begin
      w_cap = r_acc + product;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= {(2*WIDTH){1'b0}};
    end else if (acc_clr) begin
      r_acc <= {(2*WIDTH){1'b0}};
    end else if (w_capture) begin
      r_acc <= w_cap;
    end else begin
      r_acc <= r_acc;
    end
  end
`else
  always_comb begin
    w_cap = product;
  end
`endif

  // Handshake flags are set together with the next state so they never depend on same-cycle inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= LOAD_A;
      r_cnt     <= 3'd0;
      r_result  <= {(2*WIDTH){1'b0}};
      op_a      <= {WIDTH{1'b0}};
      op_b      <= {WIDTH{1'b0}};
      out_data  <= {WIDTH{1'b0}};
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        LOAD_A: begin
          if (in_valid) begin
            op_a    <= in_data;
            r_state <= LOAD_B;
            busy    <= 1'b1;
          end
        end
        LOAD_B: begin
          if (in_valid) begin
            op_b     <= in_data;
            r_cnt    <= 3'd0;
            r_state  <= CALC;
            in_ready <= 1'b0;
          end
        end
        CALC: begin
          if (w_capture) begin
            r_result  <= w_cap;
            out_data  <= w_cap[WIDTH-1:0];
            out_valid <= 1'b1;
            r_state   <= OUT_LO;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        OUT_LO: begin
          if (out_ready) begin
            out_data <= r_result[2*WIDTH-1:WIDTH];
            r_state  <= OUT_HI;
          end
        end
        OUT_HI: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            r_state   <= LOAD_A;
          end
        end
        default: begin
          r_state   <= LOAD_A;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// Directed self-checking bench: one instance with MUL_LAT=0, one with MUL_LAT=3.
module tb_mult_operand_sequencer;

  logic        clk = 1'b0;
  logic        rst;

  logic [7:0]  in_data0, op_a0, op_b0, out_data0;
  logic        in_valid0, in_ready0, out_valid0, out_ready0, busy0;
  logic [15:0] prod0;
  logic        acc_clr0;

  logic [7:0]  in_data3, op_a3, op_b3, out_data3;
  logic        in_valid3, in_ready3, out_valid3, out_ready3, busy3;
  logic [15:0] prod3;
  logic        acc_clr3;

  int checks = 0;
  int errors = 0;

  assign prod0 = 16'(op_a0) * 16'(op_b0);
  assign prod3 = 16'(op_a3) * 16'(op_b3);

  always #5 clk = ~clk;

  mult_operand_sequencer #(.WIDTH(8), .MUL_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
    .op_a(op_a0), .op_b(op_b0), .product(prod0), .out_data(out_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .busy(busy0)
`ifdef MULT_ACCUM_EN
    , .acc_clr(acc_clr0)
`endif
  );

  mult_operand_sequencer #(.WIDTH(8), .MUL_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .op_a(op_a3), .op_b(op_b3), .product(prod3), .out_data(out_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .busy(busy3)
`ifdef MULT_ACCUM_EN
    , .acc_clr(acc_clr3)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full back-to-back transaction on dut0 with out_ready held high.
  task automatic txn0(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] lo, input logic [7:0] hi);
    out_ready0 = 1'b1;
    in_valid0  = 1'b1;
    in_data0   = a;
    tick();
    in_data0   = b;
    tick();
    in_valid0  = 1'b0;
    tick();
    chk({tag, "_vld_lo"}, 16'(out_valid0), 16'd1);
    chk({tag, "_lo"}, 16'(out_data0), 16'(lo));
    tick();
    chk({tag, "_hi"}, 16'(out_data0), 16'(hi));
    tick();
    chk({tag, "_rdy_back"}, 16'(in_ready0), 16'd1);
  endtask

  initial begin
    rst = 1'b1;
    in_data0 = 8'h00; in_valid0 = 1'b0; out_ready0 = 1'b0;
    in_data3 = 8'h00; in_valid3 = 1'b0; out_ready3 = 1'b0;
`ifdef MULT_ACCUM_EN
    acc_clr0 = 1'b1;
`else
    acc_clr0 = 1'b0;
`endif
    acc_clr3 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    chk("rst_in_ready", 16'(in_ready0), 16'd1);
    chk("rst_out_valid", 16'(out_valid0), 16'd0);
    chk("rst_out_data", 16'(out_data0), 16'd0);
    chk("rst_busy", 16'(busy0), 16'd0);
    chk("rst_op_a", 16'(op_a0), 16'd0);
    chk("rst_op_b", 16'(op_b0), 16'd0);

    // 0x0C * 0x0D = 0x009C, step by step
    out_ready0 = 1'b1;
    in_valid0 = 1'b1; in_data0 = 8'h0C;
    tick();
    chk("t1_busy", 16'(busy0), 16'd1);
    chk("t1_rdy_b", 16'(in_ready0), 16'd1);
    in_data0 = 8'h0D;
    tick();
    in_valid0 = 1'b0;
    chk("t1_calc_rdy", 16'(in_ready0), 16'd0);
    chk("t1_calc_vld", 16'(out_valid0), 16'd0);
    chk("t1_op_a", 16'(op_a0), 16'h0C);
    chk("t1_op_b", 16'(op_b0), 16'h0D);
    tick();
    chk("t1_vld", 16'(out_valid0), 16'd1);
    chk("t1_lo", 16'(out_data0), 16'h9C);
    tick();
    chk("t1_hi", 16'(out_data0), 16'h00);
    chk("t1_rdy_hi", 16'(in_ready0), 16'd0);
    tick();
    chk("t1_vld_end", 16'(out_valid0), 16'd0);
    chk("t1_rdy_end", 16'(in_ready0), 16'd1);
    chk("t1_busy_end", 16'(busy0), 16'd0);

    // MUL_LAT=3: 0xFF * 0xFF = 0xFE01, valid four cycles after B
    out_ready3 = 1'b1;
    in_valid3 = 1'b1; in_data3 = 8'hFF;
    tick();
    tick();
    in_valid3 = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("t2_wait%0d", i), 16'(out_valid3), 16'd0);
    end
    tick();
    chk("t2_vld", 16'(out_valid3), 16'd1);
    chk("t2_lo", 16'(out_data3), 16'h01);
    tick();
    chk("t2_hi", 16'(out_data3), 16'hFE);
    tick();
    chk("t2_end", 16'(out_valid3), 16'd0);

    // 0x10 * 0x10 with a five-cycle output stall
    out_ready0 = 1'b0;
    in_valid0 = 1'b1; in_data0 = 8'h10;
    tick();
    tick();
    in_valid0 = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_stall_vld%0d", i), 16'(out_valid0), 16'd1);
      chk($sformatf("t3_stall_lo%0d", i), 16'(out_data0), 16'h00);
      tick();
    end
    chk("t3_stall_lo_last", 16'(out_data0), 16'h00);
    out_ready0 = 1'b1;
    tick();
    chk("t3_hi", 16'(out_data0), 16'h01);
    tick();
    chk("t3_end", 16'(out_valid0), 16'd0);

    // Gapped input: 0x03 then idle then 0x05
    in_valid0 = 1'b1; in_data0 = 8'h03;
    tick();
    in_valid0 = 1'b0; in_data0 = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t4_gap_rdy%0d", i), 16'(in_ready0), 16'd1);
      chk($sformatf("t4_gap_opb%0d", i), 16'(op_b0), 16'h10);
    end
    in_valid0 = 1'b1; in_data0 = 8'h05;
    tick();
    in_valid0 = 1'b0;
    chk("t4_op_b", 16'(op_b0), 16'h05);
    tick();
    chk("t4_lo", 16'(out_data0), 16'h0F);
    tick();
    chk("t4_hi", 16'(out_data0), 16'h00);
    tick();

    // Reset while in CALC discards the transaction
    in_valid0 = 1'b1; in_data0 = 8'h07;
    tick();
    in_data0 = 8'h09;
    tick();
    in_valid0 = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_rst_rdy", 16'(in_ready0), 16'd1);
    chk("t5_rst_vld", 16'(out_valid0), 16'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t5_no_vld%0d", i), 16'(out_valid0), 16'd0);
    end
    chk("t5_op_a", 16'(op_a0), 16'd0);
    chk("t5_op_b", 16'(op_b0), 16'd0);
    txn0("t5_next", 8'h02, 8'h03, 8'h06, 8'h00);

`ifdef MULT_ACCUM_EN
    acc_clr0 = 1'b0;
    txn0("acc_first", 8'hFF, 8'hFF, 8'h01, 8'hFE);
    txn0("acc_second", 8'hFF, 8'hFF, 8'h02, 8'hFC);
    acc_clr0 = 1'b1;
    tick();
    acc_clr0 = 1'b0;
    txn0("acc_cleared", 8'h02, 8'h03, 8'h06, 8'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
